// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller: states, instruction fields,
// ALU/PC/write-back codes and the instruction classifier. CTRL_SHIFT_IMM_EN enables LSHI.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_JUMP   = 3'd4,
    S_BRANCH = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    IC_ILLEGAL, IC_ALU_R, IC_ALU_I, IC_LOAD, IC_STOR, IC_JCOND, IC_JAL, IC_BCOND
  } iclass_e;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_SPEC  = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Register-op ext codes equal the matching immediate-op opcodes.
  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_OR  = 4'b0010;
  localparam logic [3:0] FN_XOR = 4'b0011;
  localparam logic [3:0] FN_ADD = 4'b0101;
  localparam logic [3:0] FN_SUB = 4'b1001;
  localparam logic [3:0] FN_CMP = 4'b1011;
  localparam logic [3:0] FN_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4,  COND_LS = 4'd5,  COND_GT = 4'd6,  COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8,  COND_FC = 4'd9,  COND_LO = 4'd10, COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12, COND_GE = 4'd13, COND_UC = 4'd14;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_CMP  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_LSH  = 4'b0111;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;
  localparam logic [1:0] PC_DISP = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PASS = 2'b10;
  localparam logic [1:0] WB_LINK = 2'b11;

  typedef struct packed {
    iclass_e    cls;
    logic [3:0] alu;
    logic       rf_we;
    logic       flags_we;
    logic [1:0] wb;
  } dec_t;

  function automatic dec_t illegal_dec();
    dec_t d;
    d.cls      = IC_ILLEGAL;
    d.alu      = ALU_NONE;
    d.rf_we    = 1'b0;
    d.flags_we = 1'b0;
    d.wb       = WB_ALU;
    return d;
  endfunction

  function automatic dec_t arith(input logic [3:0] fn, input logic is_imm);
    dec_t d;
    d = illegal_dec();
    d.cls   = is_imm ? IC_ALU_I : IC_ALU_R;
    d.rf_we = 1'b1;
    case (fn)
      FN_AND: d.alu = ALU_AND;
      FN_OR:  d.alu = ALU_OR;
      FN_XOR: d.alu = ALU_XOR;
      FN_ADD: begin d.alu = ALU_ADD; d.flags_we = 1'b1; end
      FN_SUB: begin d.alu = ALU_SUB; d.flags_we = 1'b1; end
      FN_CMP: begin d.alu = ALU_CMP; d.flags_we = 1'b1; d.rf_we = 1'b0; end
      FN_MOV: d.wb = WB_PASS;
      default: d = illegal_dec();
    endcase
    return d;
  endfunction

  function automatic dec_t decode(input logic [3:0] op, input logic [3:0] ext);
    dec_t d;
    d = illegal_dec();
    case (op)
      OP_REG: d = arith(ext, 1'b0);
      OP_SPEC: begin
        case (ext)
          EXT_LOAD:  d.cls = IC_LOAD;
          EXT_STOR:  d.cls = IC_STOR;
          EXT_JAL:   d.cls = IC_JAL;
          EXT_JCOND: d.cls = IC_JCOND;
          default:   d.cls = IC_ILLEGAL;
        endcase
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH) begin
          d.cls = IC_ALU_R; d.alu = ALU_LSH; d.rf_we = 1'b1;
        end
`ifdef CTRL_SHIFT_IMM_EN
        else if (ext[3:1] == 3'b000) begin
          d.cls = IC_ALU_I; d.alu = ALU_LSH; d.rf_we = 1'b1;
        end
`endif
      end
      OP_BCOND: d.cls = IC_BCOND;
      OP_LUI: begin
        d.cls = IC_ALU_I; d.alu = ALU_LUI; d.rf_we = 1'b1;
      end
      default: d = arith(op, 1'b1);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition code against the processor status flags.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic       c_i,
  input  logic       l_i,
  input  logic       f_i,
  input  logic       z_i,
  input  logic       n_i,
  output logic       take_o
);

  // NOTE: assign a default before the case so no path leaves take_o unassigned (latch).
  always_comb begin
    take_o = 1'b0;
    case (cond_i)
      COND_EQ: take_o = z_i;
      COND_NE: take_o = !z_i;
      COND_CS: take_o = c_i;
      COND_CC: take_o = !c_i;
      COND_HI: take_o = l_i;
      COND_LS: take_o = !l_i;
      COND_GT: take_o = n_i;
      COND_LE: take_o = !n_i;
      COND_FS: take_o = f_i;
      COND_FC: take_o = !f_i;
      COND_LO: take_o = !l_i && !z_i;
      COND_HS: take_o = l_i || z_i;
      COND_LT: take_o = !n_i && !z_i;
      COND_GE: take_o = n_i || z_i;
      COND_UC: take_o = 1'b1;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor control FSM: fetch/decode/execute sequencing, memory wait timeout
// and sticky trap. Define CTRL_SHIFT_IMM_EN to accept the LSHI instruction.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                C,
  input  logic                L,
  input  logic                F,
  input  logic                Z,
  input  logic                N,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_op,
  output logic                ir_load,
  output logic                src_load,
  output logic                dst_load,
  output logic                imm_load,
  output logic                rf_write,
  output logic                flags_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                out,
  output logic [1:0]          wb_sel,
  output logic                addr_sel,
  output logic                illegal,
  output logic [2:0]          state_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              wait_last;
  logic              take;
  dec_t              dec;
  logic              unused_instr;

  assign dec          = decode(instr[INSTR_W-1 -: 4], instr[7:4]);
  assign unused_instr = ^instr;

  cond_eval u_cond (
    .cond_i (instr[INSTR_W-5 -: 4]),
    .c_i    (C),
    .l_i    (L),
    .f_i    (F),
    .z_i    (Z),
    .n_i    (N),
    .take_o (take)
  );

  // The final wait cycle: one more cycle without mem_ready would reach MEM_TIMEOUT.
  assign wait_last = (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

  always_comb begin
    state_d     = state_q;
    alu_op      = '0;
    pc_op       = PC_HOLD;
    wb_sel      = WB_ALU;
    ir_load     = 1'b0;
    src_load    = 1'b0;
    dst_load    = 1'b0;
    imm_load    = 1'b0;
    rf_write    = 1'b0;
    flags_write = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    out         = 1'b0;
    addr_sel    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_last) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        case (dec.cls)
          IC_ALU_R:          begin src_load = 1'b1; dst_load = 1'b1; state_d = S_EXEC; end
          IC_ALU_I:          begin imm_load = 1'b1; dst_load = 1'b1; state_d = S_EXEC; end
          IC_LOAD, IC_STOR:  state_d = S_MEM;
          IC_JCOND, IC_JAL:  state_d = S_JUMP;
          IC_BCOND:          state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        alu_op      = ALU_OP_W'(dec.alu);
        rf_write    = dec.rf_we;
        flags_write = dec.flags_we;
        wb_sel      = dec.wb;
        pc_op       = PC_INC;
        state_d     = S_FETCH;
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (dec.cls == IC_LOAD) begin
          mem_read = 1'b1;
          wb_sel   = WB_MEM;
        end else begin
          mem_write = 1'b1;
        end
        if (mem_ready) begin
          rf_write = (dec.cls == IC_LOAD);
          pc_op    = PC_INC;
          state_d  = S_FETCH;
        end else if (wait_last) begin
          state_d = S_TRAP;
        end
      end
      S_JUMP: begin
        state_d = S_FETCH;
        if (dec.cls == IC_JAL) begin
          rf_write = 1'b1;
          wb_sel   = WB_LINK;
          pc_op    = PC_REG;
        end else begin
          pc_op = take ? PC_REG : PC_INC;
        end
      end
      S_BRANCH: begin
        pc_op   = take ? PC_DISP : PC_INC;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Reset silences the datapath immediately, aborting any bus access in flight.
    if (!reset) begin
      alu_op      = '0;
      pc_op       = PC_HOLD;
      wb_sel      = WB_ALU;
      ir_load     = 1'b0;
      src_load    = 1'b0;
      dst_load    = 1'b0;
      imm_load    = 1'b0;
      rf_write    = 1'b0;
      flags_write = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = 1'b0;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = '0;
    end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign illegal_d = illegal_q || (state_d == S_TRAP);

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus hand-written wait/timeout/reset sequences.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3;
  localparam logic [2:0] ST_JUMP = 3'd4, ST_BRANCH = 3'd5, ST_TRAP = 3'd6;

  localparam logic [10:0] IR  = 11'h400, SRC = 11'h200, DST = 11'h100, IMM = 11'h080;
  localparam logic [10:0] RF  = 11'h040, FW  = 11'h020, MR  = 11'h010, MW  = 11'h008;
  localparam logic [10:0] ADR = 11'h002, ILL = 11'h001, NONE = 11'h000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        C, L, F, Z, N;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic [1:0]  pc_op, wb_sel;
  logic        ir_load, src_load, dst_load, imm_load, rf_write, flags_write;
  logic        mem_read, mem_write, out, addr_sel, illegal;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr),
    .C(C), .L(L), .F(F), .Z(Z), .N(N), .mem_ready(mem_ready),
    .alu_op(alu_op), .pc_op(pc_op), .ir_load(ir_load), .src_load(src_load),
    .dst_load(dst_load), .imm_load(imm_load), .rf_write(rf_write),
    .flags_write(flags_write), .mem_read(mem_read), .mem_write(mem_write),
    .out(out), .wb_sel(wb_sel), .addr_sel(addr_sel), .illegal(illegal),
    .state_o(state_o)
  );

  // {state, alu_op, pc_op, wb_sel, ir, src, dst, imm, rf, fw, mr, mw, out, addr, illegal}
  logic [21:0] act;
  assign act = {state_o, alu_op, pc_op, wb_sel, ir_load, src_load, dst_load, imm_load,
                rf_write, flags_write, mem_read, mem_write, out, addr_sel, illegal};

  function automatic logic [21:0] mk(input logic [2:0] st, input logic [3:0] alu,
                                     input logic [1:0] pc, input logic [1:0] wb,
                                     input logic [10:0] en);
    return {st, alu, pc, wb, en};
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  flg;     // {C,L,F,Z,N}
    logic [2:0]  st;
    logic [10:0] dec_en;
    logic [3:0]  alu;
    logic [1:0]  pc;
    logic [1:0]  wb;
    logic [10:0] ex_en;
  } vec_t;

  vec_t vecs [0:39];
  int   nv = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic [15:0] i, input logic [4:0] f, input logic [2:0] st,
                     input logic [10:0] de, input logic [3:0] alu, input logic [1:0] pc,
                     input logic [1:0] wb, input logic [10:0] ee);
    vecs[nv] = '{i, f, st, de, alu, pc, wb, ee};
    nv++;
  endtask

  task automatic check(input string name, input logic [21:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] i, input logic [4:0] f, input logic r);
    instr = i;
    {C, L, F, Z, N} = f;
    mem_ready = r;
    #1;
  endtask

  task automatic apply(input logic [15:0] i, input logic [4:0] f, input logic r);
    @(negedge clk);
    drive(i, f, r);
  endtask

  // Reset asserted away from the clock edge; ends at a negedge with reset released.
  task automatic pulse_reset(input string name);
    reset = 1'b0;
    #1;
    check(name, mk(ST_FETCH, 4'b0, 2'b00, 2'b00, NONE));
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    add(16'h0251, 5'b00000, ST_EXEC,   SRC|DST, 4'b1000, 2'b01, 2'b00, RF|FW);  // ADD
    add(16'h0391, 5'b00000, ST_EXEC,   SRC|DST, 4'b0001, 2'b01, 2'b00, RF|FW);  // SUB
    add(16'h02B1, 5'b00000, ST_EXEC,   SRC|DST, 4'b0010, 2'b01, 2'b00, FW);     // CMP
    add(16'h0211, 5'b00000, ST_EXEC,   SRC|DST, 4'b0011, 2'b01, 2'b00, RF);     // AND
    add(16'h0221, 5'b00000, ST_EXEC,   SRC|DST, 4'b0100, 2'b01, 2'b00, RF);     // OR
    add(16'h0231, 5'b00000, ST_EXEC,   SRC|DST, 4'b0101, 2'b01, 2'b00, RF);     // XOR
    add(16'h02D1, 5'b00000, ST_EXEC,   SRC|DST, 4'b0000, 2'b01, 2'b10, RF);     // MOV
    add(16'h5205, 5'b00000, ST_EXEC,   IMM|DST, 4'b1000, 2'b01, 2'b00, RF|FW);  // ADDI
    add(16'h9205, 5'b00000, ST_EXEC,   IMM|DST, 4'b0001, 2'b01, 2'b00, RF|FW);  // SUBI
    add(16'hB205, 5'b00000, ST_EXEC,   IMM|DST, 4'b0010, 2'b01, 2'b00, FW);     // CMPI
    add(16'h1205, 5'b00000, ST_EXEC,   IMM|DST, 4'b0011, 2'b01, 2'b00, RF);     // ANDI
    add(16'hD2FF, 5'b00000, ST_EXEC,   IMM|DST, 4'b0000, 2'b01, 2'b10, RF);     // MOVI
    add(16'hF212, 5'b00000, ST_EXEC,   IMM|DST, 4'b0110, 2'b01, 2'b00, RF);     // LUI
    add(16'h8241, 5'b00000, ST_EXEC,   SRC|DST, 4'b0111, 2'b01, 2'b00, RF);     // LSH
    add(16'h4200, 5'b00000, ST_MEM,    NONE, 4'b0000, 2'b01, 2'b01, MR|ADR|RF); // LOAD
    add(16'h4241, 5'b00000, ST_MEM,    NONE, 4'b0000, 2'b01, 2'b00, MW|ADR);    // STOR
    add(16'h40C3, 5'b00010, ST_JUMP,   NONE, 4'b0000, 2'b10, 2'b00, NONE);      // JEQ Z=1
    add(16'h40C3, 5'b00000, ST_JUMP,   NONE, 4'b0000, 2'b01, 2'b00, NONE);      // JEQ Z=0
    add(16'h4381, 5'b00000, ST_JUMP,   NONE, 4'b0000, 2'b10, 2'b11, RF);        // JAL
    add(16'h4DC3, 5'b00001, ST_JUMP,   NONE, 4'b0000, 2'b10, 2'b00, NONE);      // JGE N=1
    add(16'h47C3, 5'b11110, ST_JUMP,   NONE, 4'b0000, 2'b10, 2'b00, NONE);      // JLE N=0
    add(16'h45C3, 5'b00000, ST_JUMP,   NONE, 4'b0000, 2'b10, 2'b00, NONE);      // JLS L=0
    add(16'h44C3, 5'b00000, ST_JUMP,   NONE, 4'b0000, 2'b01, 2'b00, NONE);      // JHI L=0
    add(16'h4BC3, 5'b00010, ST_JUMP,   NONE, 4'b0000, 2'b10, 2'b00, NONE);      // JHS Z=1
    add(16'hCE05, 5'b00000, ST_BRANCH, NONE, 4'b0000, 2'b11, 2'b00, NONE);      // BUC
    add(16'hC105, 5'b00010, ST_BRANCH, NONE, 4'b0000, 2'b01, 2'b00, NONE);      // BNE Z=1
    add(16'hCA05, 5'b00000, ST_BRANCH, NONE, 4'b0000, 2'b11, 2'b00, NONE);      // BLO clear
    add(16'hCA05, 5'b01000, ST_BRANCH, NONE, 4'b0000, 2'b01, 2'b00, NONE);      // BLO L=1
    add(16'hCF05, 5'b11111, ST_BRANCH, NONE, 4'b0000, 2'b01, 2'b00, NONE);      // never
    add(16'hC205, 5'b10000, ST_BRANCH, NONE, 4'b0000, 2'b11, 2'b00, NONE);      // BCS C=1
    add(16'hC305, 5'b10000, ST_BRANCH, NONE, 4'b0000, 2'b01, 2'b00, NONE);      // BCC C=1
    add(16'hC805, 5'b00100, ST_BRANCH, NONE, 4'b0000, 2'b11, 2'b00, NONE);      // BFS F=1
    add(16'hC905, 5'b00100, ST_BRANCH, NONE, 4'b0000, 2'b01, 2'b00, NONE);      // BFC F=1
    add(16'hCC05, 5'b00001, ST_BRANCH, NONE, 4'b0000, 2'b01, 2'b00, NONE);      // BLT N=1

    reset = 1'b0;
    drive(16'h0000, 5'b00000, 1'b1);
    check("reset outputs", mk(ST_FETCH, 4'b0, 2'b00, 2'b00, NONE));
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;

    for (int k = 0; k < nv; k++) begin
      apply(vecs[k].instr, vecs[k].flg, 1'b1);
      check($sformatf("v%0d fetch", k), mk(ST_FETCH, 4'b0, 2'b00, 2'b00, IR|MR));
      apply(vecs[k].instr, vecs[k].flg, 1'b1);
      check($sformatf("v%0d decode", k), mk(ST_DECODE, 4'b0, 2'b00, 2'b00, vecs[k].dec_en));
      apply(vecs[k].instr, vecs[k].flg, 1'b1);
      check($sformatf("v%0d exec", k),
            mk(vecs[k].st, vecs[k].alu, vecs[k].pc, vecs[k].wb, vecs[k].ex_en));
    end

    // LOAD with three MEM wait cycles, then FETCH timing out after 15 low cycles.
    apply(16'h4200, 5'b0, 1'b1);
    apply(16'h4200, 5'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply(16'h4200, 5'b0, 1'b0);
      check($sformatf("load wait %0d", k), mk(ST_MEM, 4'b0, 2'b00, 2'b01, MR|ADR));
    end
    apply(16'h4200, 5'b0, 1'b1);
    check("load ready", mk(ST_MEM, 4'b0, 2'b01, 2'b01, MR|ADR|RF));
    apply(16'h4200, 5'b0, 1'b0);
    check("fetch wait 1", mk(ST_FETCH, 4'b0, 2'b00, 2'b00, MR));
    for (int k = 0; k < 14; k++) apply(16'h4200, 5'b0, 1'b0);
    check("fetch wait 15", mk(ST_FETCH, 4'b0, 2'b00, 2'b00, MR));
    apply(16'h4200, 5'b0, 1'b1);
    check("fetch timeout trap", mk(ST_TRAP, 4'b0, 2'b00, 2'b00, ILL));
    apply(16'h0251, 5'b0, 1'b1);
    check("trap holds", mk(ST_TRAP, 4'b0, 2'b00, 2'b00, ILL));
    pulse_reset("reset clears trap");

    // mem_ready arriving on the timeout cycle wins.
    drive(16'h0251, 5'b0, 1'b0);
    check("post-reset fetch", mk(ST_FETCH, 4'b0, 2'b00, 2'b00, MR));
    for (int k = 0; k < 13; k++) apply(16'h0251, 5'b0, 1'b0);
    apply(16'h0251, 5'b0, 1'b1);
    check("ready on 15th", mk(ST_FETCH, 4'b0, 2'b00, 2'b00, IR|MR));
    apply(16'h0251, 5'b0, 1'b1);
    check("ready wins decode", mk(ST_DECODE, 4'b0, 2'b00, 2'b00, SRC|DST));
    apply(16'h0251, 5'b0, 1'b1);
    check("ready wins exec", mk(ST_EXEC, 4'b1000, 2'b01, 2'b00, RF|FW));

    // STOR stalling in MEM until the timeout.
    apply(16'h4241, 5'b0, 1'b1);
    apply(16'h4241, 5'b0, 1'b1);
    for (int k = 0; k < 15; k++) apply(16'h4241, 5'b0, 1'b0);
    check("mem wait 15", mk(ST_MEM, 4'b0, 2'b00, 2'b00, MW|ADR));
    apply(16'h4241, 5'b0, 1'b0);
    check("mem timeout trap", mk(ST_TRAP, 4'b0, 2'b00, 2'b00, ILL));
    pulse_reset("reset after mem trap");

    // Reset in the middle of a store drops mem_write at once.
    drive(16'h4241, 5'b0, 1'b1);
    apply(16'h4241, 5'b0, 1'b1);
    apply(16'h4241, 5'b0, 1'b0);
    check("stor in mem", mk(ST_MEM, 4'b0, 2'b00, 2'b00, MW|ADR));
    pulse_reset("reset mid-MEM");

    // Undefined opcode.
    drive(16'h7000, 5'b0, 1'b1);
    apply(16'h7000, 5'b0, 1'b1);
    check("illegal decode", mk(ST_DECODE, 4'b0, 2'b00, 2'b00, NONE));
    apply(16'h7000, 5'b0, 1'b1);
    check("illegal trap", mk(ST_TRAP, 4'b0, 2'b00, 2'b00, ILL));
    pulse_reset("reset after illegal");

    // LSHI depends on build configuration.
    drive(16'h8301, 5'b0, 1'b1);
    apply(16'h8301, 5'b0, 1'b1);
`ifdef CTRL_SHIFT_IMM_EN
    check("lshi decode", mk(ST_DECODE, 4'b0, 2'b00, 2'b00, IMM|DST));
    apply(16'h8301, 5'b0, 1'b1);
    check("lshi exec", mk(ST_EXEC, 4'b0111, 2'b01, 2'b00, RF));
`else
    check("lshi decode", mk(ST_DECODE, 4'b0, 2'b00, 2'b00, NONE));
    apply(16'h8301, 5'b0, 1'b1);
    check("lshi trap", mk(ST_TRAP, 4'b0, 2'b00, 2'b00, ILL));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter INSTR_W, default 16, SHALL set the instruction width; opcode fields sit at [INSTR_W-1:INSTR_W-4] (op), [INSTR_W-5:INSTR_W-8] (rdest/cond) and [7:4] (ext).
REQ-002 Parameter ALU_OP_W, default 4, SHALL set the alu_op width.
REQ-003 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum number of mem_ready wait cycles.
REQ-004 Port clk, in, 1: the single clock, rising-edge.
REQ-005 Port reset, in, 1: asynchronous, active-low reset.
REQ-006 Port instr, in, INSTR_W: the current instruction register contents.
REQ-007 Ports C L F Z N, in, 1 each: the processor status flags.
REQ-008 Port mem_ready, in, 1: memory has completed the current read/write.
REQ-009 Port alu_op, out, ALU_OP_W: ALU function (ADD 1000, SUB 0001, CMP 0010, AND 0011, OR 0100, XOR 0101, LUI 0110, LSH 0111).
REQ-010 Port pc_op, out, 2: 00 hold, 01 pc+1, 10 pc=Rsrc, 11 pc+=disp8.
REQ-011 Ports ir_load, src_load, dst_load, imm_load, rf_write, flags_write, mem_read, mem_write, out, 1 each: the datapath enables.
REQ-012 Port wb_sel, out, 2: 00 ALU, 01 memory, 10 operand pass (MOV/MOVI), 11 link (pc+1).
REQ-013 Port addr_sel, out, 1: 0 selects pc as the memory address, 1 selects Raddr.
REQ-014 Port illegal, out, 1: sticky flag for an illegal opcode or a memory timeout.
REQ-015 Port state_o, out, 3: the current state encoding, for debug.

Function
REQ-016 The states SHALL be FETCH, DECODE, EXEC, MEM, JUMP, BRANCH and TRAP, registered on clk.
REQ-017 FETCH SHALL assert mem_read with addr_sel=0 and hold until mem_ready; on mem_ready it SHALL assert ir_load and go to DECODE.
REQ-018 DECODE SHALL assert src_load/dst_load for register ops and imm_load/dst_load for immediate ops, then go to EXEC, MEM, JUMP or BRANCH; an undefined op/ext combination SHALL go to TRAP.
REQ-019 EXEC SHALL drive alu_op, assert rf_write (except CMP/CMPI), assert flags_write for ADD/SUB/CMP and their immediates, set pc_op=01, and return to FETCH; every ALU op therefore takes 3 cycles with zero wait.
REQ-020 MEM SHALL serve LOAD (mem_read, wb_sel=01) and STOR (mem_write) with addr_sel=1, hold until mem_ready, and assert rf_write (LOAD only) with pc_op=01 on the mem_ready cycle.
REQ-021 JUMP SHALL serve Jcond (op 0100, ext 1100) and JAL (ext 1000); JAL SHALL set rf_write=1, wb_sel=11 and pc_op=10.
REQ-022 BRANCH SHALL serve Bcond (op 1100); both JUMP and BRANCH SHALL take exactly one cycle, then return to FETCH.
REQ-023 For a taken condition, Jcond SHALL set pc_op=10 and Bcond pc_op=11; not taken SHALL give 01.
REQ-024 Condition codes: EQ0 Z; NE1 !Z; CS2 C; CC3 !C; HI4 L; LS5 !L; GT6 N; LE7 !N; FS8 F; FC9 !F; LO10 !L&!Z; HS11 L|Z; LT12 !N&!Z; GE13 N|Z; UC14 always; 15 never.
REQ-025 A wait counter of width clog2(MEM_TIMEOUT+1) SHALL clear on entry to FETCH or MEM and increment each cycle without mem_ready.
REQ-026 If the wait counter reaches MEM_TIMEOUT with no mem_ready, the block SHALL go to TRAP and set illegal.
REQ-027 mem_ready in the same cycle as the timeout SHALL win, and the normal transition SHALL occur.
REQ-028 TRAP SHALL hold all enables at 0 and pc_op=00 until reset.
REQ-029 Outputs not named for a state SHALL be 0.
REQ-030 Outputs SHALL be decoded from the state and instr only, with no combinational path from mem_ready except to ir_load, rf_write, pc_op and the next state.

Reset
REQ-031 When reset is low, the block SHALL force state FETCH, clear the wait counter, clear illegal and drive every enable to 0 asynchronously.
REQ-032 Reset asserted mid-MEM or mid-FETCH SHALL abort the access; mem_read/mem_write SHALL drop in the same instant.

Configuration
REQ-033 With CTRL_SHIFT_IMM_EN defined, LSHI (op 1000, ext 000x) SHALL decode to EXEC with alu_op=0111, imm_load=1 and rf_write=1.
REQ-034 Without CTRL_SHIFT_IMM_EN, LSHI SHALL be illegal and go to TRAP.

Structure
REQ-035 The shared package ctrl_pkg SHALL hold the state enum, the op/ext/cond constants, the alu_op codes and the pc_op/wb_sel codes.
REQ-036 Condition evaluation SHALL live in the sub-module cond_eval (cond[3:0] and flags in, take out), which is purely combinational.

Verification
REQ-037 ADD r2,r1 (0x0251) with mem_ready=1 SHALL take FETCH, DECODE, EXEC; EXEC SHALL show alu_op=1000, rf_write=1, flags_write=1 and pc_op=01.
REQ-038 LOAD (0x4200), with mem_ready low for 3 MEM cycles, SHALL give rf_write=1 and wb_sel=01 only in the 4th MEM cycle.
REQ-039 Jcond EQ (0x40C3) SHALL give pc_op=10 with Z=1 and pc_op=01 with Z=0; Bcond UC (0xCE05) SHALL give pc_op=11.
REQ-040 FETCH with mem_ready held low for 15 cycles SHALL enter TRAP with illegal=1; a following reset pulse SHALL return to FETCH with illegal=0.
REQ-041 LSHI 0x8301 SHALL reach TRAP without CTRL_SHIFT_IMM_EN and EXEC with alu_op=0111 with it.
